// File: rtl/op_add_pkg.sv
// Shared types for the op_add_pipe multi-lane adder/accumulator.
// Contents: operation codes, the per-lane combinational result record and
// a helper that tells which operations write the lane accumulator.
package op_add_pkg;

  // Beat operation code carried alongside the operands.
  typedef enum logic [1:0] {
    OP_ADD = 2'd0,  // a + b
    OP_SUB = 2'd1,  // a - b
    OP_ACC = 2'd2,  // acc + a, b ignored
    OP_CLR = 2'd3   // acc <- 0, result 0
  } op_e;

  // Widest lane the shared result record can carry; lanes narrower than
  // this zero-fill the upper value bits.
  localparam int unsigned LANE_W_MAX = 32;

  // One lane's combinational outcome, consumed at the S1->S2 transfer.
  typedef struct packed {
    logic [LANE_W_MAX-1:0] value;
    logic                  ov;
    logic                  uv;
  } lane_res_t;

  // Operations whose lane result is written back into the accumulator.
  // CLR produces a zero result, so writing it back clears the lane.
  function automatic logic op_uses_acc(input op_e op);
    return (op == OP_ACC) || (op == OP_CLR);
  endfunction

endpackage

// File: rtl/op_add_lane.sv
// One lane of op_add_pipe: combinational N+1-bit add/subtract, overflow and
// underflow detection, and optional clamping (enabled by OP_ADD_PIPE_SAT_EN).
// Ports: op_i (operation), a_i/b_i (operands), acc_i (current accumulator),
// res_o (value zero-extended to LANE_W_MAX, plus ov/uv flags). N <= LANE_W_MAX.
module op_add_lane
  import op_add_pkg::*;
#(
  parameter int N      = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic [1:0]   op_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [N-1:0] acc_i,
  output lane_res_t    res_o
);

`ifdef OP_ADD_PIPE_SAT_EN
  localparam logic [N-1:0] MAX_V = SIGNED ? {1'b0, {(N-1){1'b1}}} : {N{1'b1}};
  localparam logic [N-1:0] MIN_V = SIGNED ? {1'b1, {(N-1){1'b0}}} : {N{1'b0}};
`endif

  op_e          op;
  logic [N-1:0] opnd_x;
  logic [N-1:0] opnd_y;
  logic         is_sub;
  logic [N:0]   raw;
  logic [N-1:0] val;
  logic         ov;
  logic         uv;

  assign op = op_e'(op_i);

  always_comb begin
    // ACC adds the incoming a to the accumulator; everything else uses a/b.
    opnd_x = (op == OP_ACC) ? acc_i : a_i;
    opnd_y = (op == OP_ACC) ? a_i   : b_i;
    is_sub = (op == OP_SUB);
    raw    = is_sub ? ({1'b0, opnd_x} - {1'b0, opnd_y})
                    : ({1'b0, opnd_x} + {1'b0, opnd_y});

    if (SIGNED) begin
      // Signed range violations show up as a result sign that cannot follow
      // from the operand signs.
      if (is_sub) begin
        ov = ~opnd_x[N-1] &  opnd_y[N-1] &  raw[N-1];
        uv =  opnd_x[N-1] & ~opnd_y[N-1] & ~raw[N-1];
      end else begin
        ov = ~opnd_x[N-1] & ~opnd_y[N-1] &  raw[N-1];
        uv =  opnd_x[N-1] &  opnd_y[N-1] & ~raw[N-1];
      end
    end else begin
      // Bit N is the carry on add and the borrow on subtract.
      ov = ~is_sub & raw[N];
      uv =  is_sub & raw[N];
    end

    val = raw[N-1:0];
`ifdef OP_ADD_PIPE_SAT_EN
    if (ov) begin
      val = MAX_V;
    end else if (uv) begin
      val = MIN_V;
    end
`endif

    if (op == OP_CLR) begin
      val = '0;
      ov  = 1'b0;
      uv  = 1'b0;
    end

    res_o          = '0;
    res_o.value[N-1:0] = val;
    res_o.ov       = ov;
    res_o.uv       = uv;
  end

endmodule

// File: rtl/op_add_pipe.sv
// op_add_pipe: LANES-wide pipelined adder/accumulator, two register stages
// (S1 operands, S2 result/flags) with valid/ready on both sides.
// Ports: clk/rst (sync, active high); in_valid/in_ready/in_op/in_a/in_b;
// out_valid/out_ready/out_result/out_ov/out_uv; sticky_ov/sticky_uv with
// clr_sticky. Saturating results when OP_ADD_PIPE_SAT_EN is defined.
module op_add_pipe
  import op_add_pkg::*;
#(
  parameter int N      = 8,
  parameter int LANES  = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_op,
  input  logic [LANES*N-1:0] in_a,
  input  logic [LANES*N-1:0] in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*N-1:0] out_result,
  output logic [LANES-1:0]   out_ov,
  output logic [LANES-1:0]   out_uv,
  output logic [LANES-1:0]   sticky_ov,
  output logic [LANES-1:0]   sticky_uv,
  input  logic               clr_sticky
);

  // Stage 1: captured beat.
  logic               s1_full_q, s1_full_d;
  logic [1:0]         s1_op_q,   s1_op_d;
  logic [LANES*N-1:0] s1_a_q,    s1_a_d;
  logic [LANES*N-1:0] s1_b_q,    s1_b_d;

  // Stage 2: result beat presented downstream.
  logic               s2_full_q, s2_full_d;
  logic [LANES*N-1:0] s2_res_q,  s2_res_d;
  logic [LANES-1:0]   s2_ov_q,   s2_ov_d;
  logic [LANES-1:0]   s2_uv_q,   s2_uv_d;

  // Per-lane accumulators and sticky status.
  logic [LANES*N-1:0] acc_q,       acc_d;
  logic [LANES-1:0]   sticky_ov_q, sticky_ov_d;
  logic [LANES-1:0]   sticky_uv_q, sticky_uv_d;

  // Handshake terms.
  logic s2_can_load;
  logic s2_load;
  logic s1_load;

  // Lane outputs.
  lane_res_t          lane_res [LANES];
  logic [LANES*N-1:0] lane_val;
  logic [LANES-1:0]   lane_ov;
  logic [LANES-1:0]   lane_uv;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    op_add_lane #(
      .N      (N),
      .SIGNED (SIGNED)
    ) u_lane (
      .op_i  (s1_op_q),
      .a_i   (s1_a_q[g*N +: N]),
      .b_i   (s1_b_q[g*N +: N]),
      .acc_i (acc_q[g*N +: N]),
      .res_o (lane_res[g])
    );

    assign lane_val[g*N +: N] = lane_res[g].value[N-1:0];
    assign lane_ov[g]         = lane_res[g].ov;
    assign lane_uv[g]         = lane_res[g].uv;
  end

  // in_ready depends only on stage occupancy, out_ready and rst, never on
  // in_valid, so upstream sees no combinational loop through this block.
  always_comb begin
    s2_can_load = !s2_full_q || out_ready;
    s2_load     = s1_full_q && s2_can_load;
    in_ready    = !rst && (!s1_full_q || s2_can_load);
    s1_load     = in_valid && in_ready;
  end

  always_comb begin
    s1_full_d = s1_full_q;
    s1_op_d   = s1_op_q;
    s1_a_d    = s1_a_q;
    s1_b_d    = s1_b_q;
    if (s1_load) begin
      s1_full_d = 1'b1;
      s1_op_d   = in_op;
      s1_a_d    = in_a;
      s1_b_d    = in_b;
    end else if (s2_load) begin
      s1_full_d = 1'b0;
    end
  end

  always_comb begin
    s2_full_d = s2_full_q;
    s2_res_d  = s2_res_q;
    s2_ov_d   = s2_ov_q;
    s2_uv_d   = s2_uv_q;
    if (s2_load) begin
      s2_full_d = 1'b1;
      s2_res_d  = lane_val;
      s2_ov_d   = lane_ov;
      s2_uv_d   = lane_uv;
    end else if (out_ready) begin
      s2_full_d = 1'b0;
    end
  end

  // The accumulator is written on the same edge its result moves into S2,
  // so a following ACC beat sitting in S1 already reads the updated value.
  always_comb begin
    acc_d = acc_q;
    if (s2_load && op_uses_acc(op_e'(s1_op_q))) begin
      acc_d = lane_val;
    end
  end

  // A flagged load in the same cycle as clr_sticky leaves the flag set.
  always_comb begin
    sticky_ov_d = (clr_sticky ? '0 : sticky_ov_q) | (s2_load ? lane_ov : '0);
    sticky_uv_d = (clr_sticky ? '0 : sticky_uv_q) | (s2_load ? lane_uv : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_full_q   <= 1'b0;
      s1_op_q     <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s2_full_q   <= 1'b0;
      s2_res_q    <= '0;
      s2_ov_q     <= '0;
      s2_uv_q     <= '0;
      acc_q       <= '0;
      sticky_ov_q <= '0;
      sticky_uv_q <= '0;
    end else begin
      s1_full_q   <= s1_full_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s2_full_q   <= s2_full_d;
      s2_res_q    <= s2_res_d;
      s2_ov_q     <= s2_ov_d;
      s2_uv_q     <= s2_uv_d;
      acc_q       <= acc_d;
      sticky_ov_q <= sticky_ov_d;
      sticky_uv_q <= sticky_uv_d;
    end
  end

  assign out_valid  = s2_full_q;
  assign out_result = s2_res_q;
  assign out_ov     = s2_ov_q;
  assign out_uv     = s2_uv_q;
  assign sticky_ov  = sticky_ov_q;
  assign sticky_uv  = sticky_uv_q;

endmodule

// File: tb/tb_op_add_pipe.sv
// Directed bench for op_add_pipe: an unsigned 4-lane instance and a signed
// 1-lane instance share clock and reset. Expected values are hand-computed;
// saturating expectations apply when OP_ADD_PIPE_SAT_EN is defined.
module tb_op_add_pipe;
  import op_add_pkg::*;

`ifdef OP_ADD_PIPE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;

  // Unsigned, 4 lanes of 8 bits.
  logic        in_valid, in_ready, out_valid, out_ready, clr_sticky;
  logic [1:0]  in_op;
  logic [31:0] in_a, in_b, out_result;
  logic [3:0]  out_ov, out_uv, sticky_ov, sticky_uv;

  // Signed, 1 lane of 8 bits.
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_clr_sticky;
  logic [1:0]  s_in_op;
  logic [7:0]  s_in_a, s_in_b, s_out_result;
  logic [0:0]  s_out_ov, s_out_uv, s_sticky_ov, s_sticky_uv;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  op_add_pipe #(.N(8), .LANES(4), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_ov(out_ov), .out_uv(out_uv),
    .sticky_ov(sticky_ov), .sticky_uv(sticky_uv), .clr_sticky(clr_sticky)
  );

  op_add_pipe #(.N(8), .LANES(1), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_op(s_in_op),
    .in_a(s_in_a), .in_b(s_in_b),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_result(s_out_result),
    .out_ov(s_out_ov), .out_uv(s_out_uv),
    .sticky_ov(s_sticky_ov), .sticky_uv(s_sticky_uv), .clr_sticky(s_clr_sticky)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one beat at a negedge; returns at the negedge after acceptance.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    #1 check("issue.rdy", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // One isolated beat: not visible one cycle after acceptance, visible the
  // next, then consumed (out_ready high).
  task automatic single(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input logic [3:0] exp_ov,
                        input logic [3:0] exp_uv);
    issue(op, a, b);
    check({tag, ".lat"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check({tag, ".vld"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".res"}, out_result, exp_r);
    check({tag, ".ov"},  {28'd0, out_ov}, {28'd0, exp_ov});
    check({tag, ".uv"},  {28'd0, out_uv}, {28'd0, exp_uv});
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  k;
    logic [31:0] exp_q[$];
    int          sent;
    int          got;

    rst = 1'b1;
    in_valid = 1'b0; in_op = 2'd0; in_a = '0; in_b = '0;
    out_ready = 1'b1; clr_sticky = 1'b0;
    s_in_valid = 1'b0; s_in_op = 2'd0; s_in_a = '0; s_in_b = '0;
    s_out_ready = 1'b1; s_clr_sticky = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst.vld",    {31'd0, out_valid}, 32'd0);
    check("rst.res",    out_result, 32'd0);
    check("rst.sov",    {28'd0, sticky_ov}, 32'd0);
    check("rst.suv",    {28'd0, sticky_uv}, 32'd0);
    check("rst.rdy",    {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Unsigned 200+100 -> 44 with carry (255 saturated).
    single("add_ov", OP_ADD, {4{8'd200}}, {4{8'd100}},
           SAT ? {4{8'd255}} : {4{8'd44}}, 4'hf, 4'h0);
    check("add_ov.sov", {28'd0, sticky_ov}, 32'hf);
    check("add_ov.suv", {28'd0, sticky_uv}, 32'h0);

    // clr_sticky on its own clears.
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    check("clr1.sov", {28'd0, sticky_ov}, 32'h0);

    // Unsigned 5-7 -> 254 with borrow (0 saturated).
    single("sub_uv", OP_SUB, {4{8'd5}}, {4{8'd7}},
           SAT ? 32'd0 : {4{8'd254}}, 4'h0, 4'hf);
    check("sub_uv.suv", {28'd0, sticky_uv}, 32'hf);
    check("sub_uv.sov", {28'd0, sticky_ov}, 32'h0);

    // Mixed lanes: lane3 1+1, lane2 2+3, lane1 250+10, lane0 200+100.
    single("mix", OP_ADD, {8'd1, 8'd2, 8'd250, 8'd200}, {8'd1, 8'd3, 8'd10, 8'd100},
           SAT ? {8'd2, 8'd5, 8'd255, 8'd255} : {8'd2, 8'd5, 8'd4, 8'd44},
           4'b0011, 4'b0000);
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    check("clr2.sov", {28'd0, sticky_ov}, 32'h0);
    check("clr2.suv", {28'd0, sticky_uv}, 32'h0);

    // clr_sticky in the same cycle as a flagged S2 load: set wins.
    issue(OP_ADD, {4{8'd200}}, {4{8'd100}});
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    check("clrset.vld", {31'd0, out_valid}, 32'd1);
    check("clrset.sov", {28'd0, sticky_ov}, 32'hf);
    @(negedge clk);

    // Back-to-back ACC chain, CLR, then ACC again; b carries junk.
    issue(OP_ACC, {4{8'd10}}, {4{8'hAA}});
    issue(OP_ACC, {4{8'd20}}, {4{8'hAA}});
    check("acc.r0", out_result, {4{8'd10}});
    issue(OP_ACC, {4{8'd30}}, {4{8'hAA}});
    check("acc.r1", out_result, {4{8'd30}});
    issue(OP_CLR, {4{8'h55}}, {4{8'hAA}});
    check("acc.r2", out_result, {4{8'd60}});
    issue(OP_ACC, {4{8'd1}}, {4{8'hAA}});
    check("acc.clr", out_result, 32'd0);
    check("acc.clrov", {28'd0, out_ov}, 32'd0);
    @(negedge clk);
    check("acc.r4", out_result, {4{8'd1}});
    @(negedge clk);
    check("acc.drain", {31'd0, out_valid}, 32'd0);

    // Backpressure: out_ready low for 5 cycles under continuous in_valid.
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      out_ready = (cyc >= 5);
      k         = sent[7:0] * 8'd16 + 8'd3;
      in_valid  = (sent < 6);
      in_op     = OP_ADD;
      in_a      = {4{k}};
      in_b      = {4{8'd1}};
      #1;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("stall.extra", {31'd0, out_valid}, 32'd0);
        end else if (!out_ready) begin
          check("stall.hold", out_result, exp_q[0]);
        end else begin
          check("stall.ord", out_result, exp_q.pop_front());
        end
        if (out_ready) got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({4{k + 8'd1}});
        sent++;
      end
      if (cyc == 4) begin
        check("stall.acc2", sent, 32'd2);
        check("stall.rdy0", {31'd0, in_ready}, 32'd0);
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stall.cnt", got, 32'd6);

    // Reset with both stages full and acc = 60.
    issue(OP_CLR, 32'd0, 32'd0);
    issue(OP_ADD, {4{8'd200}}, {4{8'd100}});
    issue(OP_ACC, {4{8'd10}}, 32'd0);
    issue(OP_ACC, {4{8'd20}}, 32'd0);
    issue(OP_ACC, {4{8'd30}}, 32'd0);
    issue(OP_ADD, {4{8'd1}}, {4{8'd1}});
    out_ready = 1'b0;
    check("rfull.res", out_result, {4{8'd60}});
    check("rfull.sov", {28'd0, sticky_ov}, 32'hf);
    @(negedge clk);
    check("rfull.rdy", {31'd0, in_ready}, 32'd0);
    check("rfull.hold", out_result, {4{8'd60}});
    rst = 1'b1;
    @(negedge clk);
    check("rmid.vld", {31'd0, out_valid}, 32'd0);
    check("rmid.sov", {28'd0, sticky_ov}, 32'd0);
    check("rmid.rdy", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("rmid.nobeat", {31'd0, out_valid}, 32'd0);
    issue(OP_ACC, {4{8'd3}}, 32'd0);
    @(negedge clk);
    check("rmid.acc3", out_result, {4{8'd3}});
    @(negedge clk);
    check("rmid.drain", {31'd0, out_valid}, 32'd0);

    // Signed: 100+100 -> -56 (0xC8) ov; saturating 127.
    s_in_op = OP_ADD; s_in_a = 8'd100; s_in_b = 8'd100; s_in_valid = 1'b1;
    @(negedge clk);
    s_in_valid = 1'b0;
    @(negedge clk);
    check("sadd.vld", {31'd0, s_out_valid}, 32'd1);
    check("sadd.res", {24'd0, s_out_result}, SAT ? 32'h7f : 32'hc8);
    check("sadd.ov",  {31'd0, s_out_ov}, 32'd1);
    check("sadd.uv",  {31'd0, s_out_uv}, 32'd0);
    // Signed: -100-100 -> wraps to 56 (0x38) uv; saturating -128.
    s_in_op = OP_SUB; s_in_a = 8'h9c; s_in_b = 8'd100; s_in_valid = 1'b1;
    @(negedge clk);
    s_in_valid = 1'b0;
    @(negedge clk);
    check("ssub.res", {24'd0, s_out_result}, SAT ? 32'h80 : 32'h38);
    check("ssub.ov",  {31'd0, s_out_ov}, 32'd0);
    check("ssub.uv",  {31'd0, s_out_uv}, 32'd1);
    check("ssub.suv", {31'd0, s_sticky_uv}, 32'd1);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/op_add_pipe.md
# op_add_pipe

Parametrised, pipelined multi-lane adder/accumulator with valid/ready flow control, the next-generation replacement for the single-lane registered adder in the arithmetic datapath. Each beat carries one operand pair per lane and an operation code (add, subtract, accumulate, clear). Results leave two cycles after acceptance with per-lane overflow/underflow flags and sticky status. It sits between the operand-fetch stage and downstream consumers that may apply backpressure.

## Interface
- N, 8: lane data width in bits, ≥2
- LANES, 4: number of independent lanes, ≥1
- SIGNED, 0: 0 = unsigned two's-complement wrap semantics, 1 = signed
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  beat offered
- in_ready  output  1  beat accepted when in_valid && in_ready
- in_op  input  2  0 ADD (a+b), 1 SUB (a−b), 2 ACC (acc+a, b ignored), 3 CLR (acc←0)
- in_a  input  LANES*N  lane i at [i*N +: N]
- in_b  input  LANES*N  lane i at [i*N +: N]
- out_valid  output  1  result beat present
- out_ready  input  1  consumer takes beat when out_valid && out_ready
- out_result  output  LANES*N  per-lane result
- out_ov  output  LANES  per-lane overflow for this beat
- out_uv  output  LANES  per-lane underflow for this beat
- sticky_ov  output  LANES  OR of out_ov over all delivered beats since last clear
- sticky_uv  output  LANES  as above for out_uv
- clr_sticky  input  1  clears sticky flags

## Operation
- Two register stages: S1 captures op and operands; S2 holds result and flags. Per-lane accumulator acc[i] (N bits).
- Arithmetic in N+1 bits. Unsigned: ADD/ACC ov = carry out; SUB uv = borrow (a<b); uv never set on ADD, ov never on SUB. Signed: ov = result exceeds 2^(N−1)−1, uv = result below −2^(N−1), detected from operand/result sign bits.
- Result = low N bits (wrap) unless saturation compiled in.
- ACC: acc[i] updated with result at S1→S2 transfer; back-to-back ACC beats chain correctly with no bubble (result read from acc register, never stale).
- CLR: acc[i]←0; output beat delivered with result 0, flags 0.
- ADD/SUB never modify acc.
- Sticky flags set at S2 load from that beat's flags; clr_sticky same cycle as a flagged load → sticky ends set (set wins).

## Timing
- Reset (rst high at clk edge): out_valid=0, out_result=0, out_ov=0, out_uv=0, sticky_*=0, acc=0, S1 empty. in_ready=0 while rst is high.
- Latency: beat accepted at edge k appears at out_valid at edge k+2 (no stall).
- Throughput: one beat per cycle while out_ready high.
- Stage advance: S2 loads when empty or being consumed; S1 loads when empty or transferring to S2. in_ready = !S1_full || S2 can load (combinational from out_ready, no combinational path from in_valid).
- out_valid held high with out_result/out_ov/out_uv stable until consumed.
- Stall with both stages full: in_ready=0, no state change including acc.
- rst mid-operation: all in-flight beats discarded, no output beat generated.

## Configuration
- OP_ADD_PIPE_SAT_EN defined: on ov, result clamps to max (2^N−1 unsigned, 2^(N−1)−1 signed); on uv, to min (0 unsigned, −2^(N−1) signed); acc stores the clamped value; flags still reported.
- Undefined: results wrap modulo 2^N; flags unchanged.

## Structure
- Package op_add_pkg: op-code enum (OP_ADD, OP_SUB, OP_ACC, OP_CLR), lane result struct (value, ov, uv).
- Sub-module op_add_lane: one lane's combinational N+1-bit add/sub, flag detection and optional saturation; instantiated LANES times via generate. Pipeline, acc and handshake stay in the top.

## Test plan
- Unsigned N=8, ADD a=200, b=100 → result 44, ov=1, sticky_ov=1; with OP_ADD_PIPE_SAT_EN → 255.
- Unsigned SUB a=5, b=7 → result 254, uv=1; saturating → 0. Signed ADD 100+100 → −56, ov=1; saturating → 127.
- ACC stream a=10,20,30 back-to-back then CLR → results 10,30,60,0; next ACC a=1 → 1.
- out_ready low 5 cycles with continuous in_valid → in_ready drops after 2 accepted beats, no beat lost/duplicated, order preserved, out_result stable.
- rst asserted with both stages full and acc=60 → next cycle out_valid=0, sticky=0; ACC a=3 after reset → 3.
- clr_sticky pulsed same cycle as flagged beat load → sticky stays 1; pulsed alone → 0.
